spi_master_sched: RTL and testbench

Mode-3 SPI master that shares one SPI bus among `NREQ` on-chip requesters and sequences one 8-bit full-duplex transfer per grant to a selected slave. It sits between requester logic and the board-level SPI pins, driving `sck`, `mosi` and per-slave `ss_n`. It is the master-side counterpart of the team's mode-3 SPI slave.

---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_rr_arbiter.sv | 38 +++
 rtl/spi_master_sched.sv | 140 ++++++++++++++
 tb/tb_spi_master_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-3 SPI master scheduler.
package spi_pkg;
  localparam int BYTE_W = 8;
  localparam logic SCK_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past each winner.
module spi_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);
  logic [PW-1:0] ptr;
  logic [PW-1:0] pick;
  logic          found;

  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NREQ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  assign gnt     = (en && found) ? (NREQ'(1) << pick) : '0;
  assign gnt_idx = pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (int'(pick) == NREQ - 1) ? '0 : pick + PW'(1);
    end
  end
endmodule

// File: rtl/spi_master_sched.sv
// Mode-3 SPI master sharing one bus among NREQ requesters, one byte per grant.
// Build option: define SPI_LSB_FIRST_EN to shift bit 0 first (default MSB first).
module spi_master_sched
  import spi_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NSS  = 2,
  parameter int DIV  = 2,
  localparam int SSW = (NSS > 1) ? $clog2(NSS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*8-1:0]      req_data,
  input  logic [NREQ*SSW-1:0]    req_ss,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [BYTE_W-1:0]      rx_data,
  output logic                   busy,
  output logic                   sck,
  output logic [NSS-1:0]         ss_n,
  output logic                   mosi,
  input  logic                   miso,
  output state_t                 state_dbg
);
  localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_n;
  logic [HW-1:0]     hcnt, hcnt_n;
  logic [3:0]        ph, ph_n;
  logic              hlast;
  logic [BYTE_W-1:0] tx_byte, rx_sh;
  logic [SSW-1:0]    sel;
  logic [NREQ-1:0]   owner;
  logic [NREQ-1:0]   arb_gnt;
  logic [PW-1:0]     gidx;
  logic              arb_en, active, ss_ok;
  logic [2:0]        bit_idx;

  // Grants only from IDLE; held off during reset so gnt reads 0 there.
  assign arb_en = (state == IDLE) && !rst;

  spi_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en),
    .req     (req),
    .gnt     (arb_gnt),
    .gnt_idx (gidx)
  );

  assign hlast = (hcnt == HW'(DIV - 1));

  always_comb begin
    state_n = state;
    hcnt_n  = hlast ? '0 : hcnt + HW'(1);
    ph_n    = ph;
    case (state)
      IDLE: begin
        hcnt_n = '0;
        ph_n   = '0;
        if (|arb_gnt) state_n = SETUP;
      end
      SETUP: if (hlast) state_n = SHIFT;
      SHIFT: begin
        if (hlast) begin
          if (ph == 4'd15) state_n = HOLD;
          else ph_n = ph + 4'd1;
        end
      end
      HOLD:  if (hlast) state_n = GAP;
      GAP:   if (hlast) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= '0;
      ph    <= '0;
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
      ph    <= ph_n;
    end
  end

  // ph counts sck half-periods in SHIFT; even = low, odd = high; ph[3:1] is the bit number.
`ifdef SPI_LSB_FIRST_EN
  assign bit_idx = ph[3:1];
`else
  assign bit_idx = 3'd7 - ph[3:1];
`endif

  assign ss_ok  = int'(sel) < NSS;
  assign active = (state == SETUP) || (state == SHIFT) || (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_byte <= '0;
      rx_sh   <= '0;
      sel     <= '0;
      owner   <= '0;
      done    <= '0;
      rx_data <= '0;
    end else begin
      done <= '0;
      if (state == IDLE && |arb_gnt) begin
        tx_byte <= req_data[gidx*8 +: 8];
        sel     <= req_ss[gidx*SSW +: SSW];
        owner   <= arb_gnt;
        rx_sh   <= '0;
      end
      if (state == SHIFT && ph[0] && hcnt == '0) rx_sh[bit_idx] <= miso;
      if (state == HOLD && hlast) begin
        done    <= owner;
        rx_data <= ss_ok ? rx_sh : 8'hFF;
      end
    end
  end

  always_comb begin
    sck  = SCK_IDLE;
    mosi = MOSI_IDLE;
    ss_n = '1;
    if (state == SHIFT) sck = ph[0];
    if (active) begin
      mosi = tx_byte[bit_idx];
      for (int k = 0; k < NSS; k++) begin
        if (ss_ok && int'(sel) == k) ss_n[k] = 1'b0;
      end
    end
  end

  assign gnt       = arb_gnt;
  assign busy      = (state != IDLE);
  assign state_dbg = state;
endmodule

// File: tb/tb_spi_master_sched.sv
// Directed bench for spi_master_sched with a mode-3 slave model on miso.
module tb_spi_master_sched;
  import spi_pkg::*;

  localparam int NREQ = 4;
  localparam int NSS  = 3;
  localparam int DIV  = 2;
  localparam int SSW  = 2;
  localparam int DONE_OFS = 18 * DIV + 1;
  localparam int NEXT_OFS = 19 * DIV + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*8-1:0]   req_data;
  logic [NREQ*SSW-1:0] req_ss;
  logic [NREQ-1:0]     gnt, done;
  logic [7:0]          rx_data;
  logic                busy, sck, mosi, miso;
  logic [NSS-1:0]      ss_n;
  state_t              state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] slave_byte = 8'h00;
  logic [2:0] slave_cnt = 3'd0;
  logic       log_en = 1'b0;
  logic [7:0] mosi_log = 8'h00;

  spi_master_sched #(.NREQ(NREQ), .NSS(NSS), .DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_ss    (req_ss),
    .gnt       (gnt),
    .done      (done),
    .rx_data   (rx_data),
    .busy      (busy),
    .sck       (sck),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .state_dbg (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode-3 slave: drive on falling sck, master samples on rising sck
  always @(negedge sck) begin
`ifdef SPI_LSB_FIRST_EN
    miso = slave_byte[slave_cnt];
`else
    miso = slave_byte[3'd7 - slave_cnt];
`endif
    slave_cnt = slave_cnt + 3'd1;
  end

  always @(posedge sck) if (log_en) mosi_log = {mosi_log[6:0], mosi};

  task automatic set_req(input int i, input logic [7:0] d, input logic [SSW-1:0] s);
    req_data[8*i +: 8]   = d;
    req_ss[SSW*i +: SSW] = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int t, output logic [NREQ-1:0] g);
    t = -1;
    g = '0;
    for (int n = 0; n < 200; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      if (gnt !== '0) begin
        t = cyc;
        g = gnt;
        break;
      end
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL grant_timeout: no gnt within 200 cycles");
    end
  endtask

  // returns the cycle offset from t at which done was seen, plus done/rx_data then
  task automatic wait_done(input int t, output int ofs, output logic [NREQ-1:0] d, output logic [7:0] rx);
    ofs = -1;
    d   = '0;
    rx  = '0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done !== '0) begin
        ofs = cyc - t;
        d   = done;
        rx  = rx_data;
        break;
      end
    end
    if (ofs < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within 100 cycles");
    end
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy stuck high");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    req_data = '0;
    req_ss = '0;
    miso = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (sck !== 1'b1) begin errors++; $display("FAIL reset_sck: got %b want 1", sck); end
    checks++; if (ss_n !== 3'b111) begin errors++; $display("FAIL reset_ss_n: got %b want 111", ss_n); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %b want 1", mosi); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    req = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int t, ofs, k;
    logic [NREQ-1:0] g, d;
    logic [7:0] rx;
    slave_byte = 8'h3C; slave_cnt = 3'd0; mosi_log = 8'h00; log_en = 1'b1;
    set_req(0, 8'hA5, 2'd1);
    req = 4'b0001;
    wait_grant(t, g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", g); end
    @(posedge clk); #1;
    req = '0;
    ofs = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      k = cyc - t;
      if (k == 1) begin
        checks++; if (ss_n !== 3'b101) begin errors++; $display("FAIL single_ss_n: got %b want 101", ss_n); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
      end
      if (k == DIV) begin
        checks++; if (sck !== 1'b1) begin errors++; $display("FAIL single_sck_setup: got %b want 1", sck); end
      end
      if (k == DIV + 1) begin
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL single_sck_fall: got %b want 0", sck); end
      end
      if (done !== '0) begin
        ofs = k; d = done; rx = rx_data;
        break;
      end
    end
    log_en = 1'b0;
    checks++; if (ofs != DONE_OFS) begin errors++; $display("FAIL single_done_time: got %0d want %0d", ofs, DONE_OFS); end
    checks++; if (d !== 4'b0001) begin errors++; $display("FAIL single_done: got %b want 0001", d); end
    checks++; if (rx !== 8'h3C) begin errors++; $display("FAIL single_rx: got %h want 3c", rx); end
    checks++; if (mosi_log !== 8'hA5) begin errors++; $display("FAIL single_mosi: got %h want a5", mosi_log); end
    @(negedge clk);
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_done_pulse: got %b want 0000", done); end
    checks++; if (ss_n !== 3'b111) begin errors++; $display("FAIL single_gap_ss_n: got %b want 111", ss_n); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int t, prev;
    logic [NREQ-1:0] g;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h10 + i), 2'd0);
    req = 4'b1111;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(t, g);
      checks++; if (g !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_order_%0d: got %b want %b", i, g, 4'(1 << (i % 4))); end
      if (i > 0) begin
        checks++; if (t - prev != NEXT_OFS) begin errors++; $display("FAIL rr_spacing_%0d: got %0d want %0d", i, t - prev, NEXT_OFS); end
      end
      prev = t;
      @(posedge clk); #1;
      if (i == 4) req = '0;
    end
    wait_idle();
  endtask

  task automatic test_pointer();
    int t, t2;
    logic [NREQ-1:0] g, g2;
    req = 4'b0100;
    wait_grant(t, g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL ptr_first: got %b want 0100", g); end
    @(posedge clk); #1;
    req = 4'b0101;
    wait_grant(t2, g2);
    checks++; if (g2 !== 4'b0001) begin errors++; $display("FAIL ptr_next: got %b want 0001", g2); end
    checks++; if (t2 - t != NEXT_OFS) begin errors++; $display("FAIL ptr_spacing: got %0d want %0d", t2 - t, NEXT_OFS); end
    @(posedge clk); #1;
    req = '0;
    wait_idle();
  endtask

  task automatic test_out_of_range();
    int t, ofs, bad;
    logic [NREQ-1:0] g, d;
    logic [7:0] rx;
    slave_byte = 8'h3C; slave_cnt = 3'd0;
    set_req(0, 8'h5A, 2'd3);
    req = 4'b0001;
    wait_grant(t, g);
    @(posedge clk); #1;
    req = '0;
    bad = 0; ofs = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ss_n !== 3'b111) bad++;
      if (done !== '0) begin
        ofs = cyc - t; d = done; rx = rx_data;
        break;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL oor_ss_n: %0d cycles with a select asserted, want 0", bad); end
    checks++; if (ofs != DONE_OFS) begin errors++; $display("FAIL oor_done_time: got %0d want %0d", ofs, DONE_OFS); end
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL oor_rx: got %h want ff", rx); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int t, seen, ofs;
    logic [NREQ-1:0] g, d;
    logic [7:0] rx;
    set_req(2, 8'hC3, 2'd0);
    req = 4'b0100;
    wait_grant(t, g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL rmid_gnt: got %b want 0100", g); end
    @(posedge clk); #1;
    req = '0;
    while (cyc < t + 10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (sck !== 1'b1) begin errors++; $display("FAIL rmid_sck: got %b want 1", sck); end
    checks++; if (ss_n !== 3'b111) begin errors++; $display("FAIL rmid_ss_n: got %b want 111", ss_n); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL rmid_mosi: got %b want 1", mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rmid_rx: got %h want 00", rx_data); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (done !== '0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_done: got %0d done pulses want 0", seen); end
    req = 4'b1111;
    wait_grant(t, g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL rmid_ptr: got %b want 0001", g); end
    @(posedge clk); #1;
    req = '0;
    wait_done(t, ofs, d, rx);
    wait_idle();
  endtask

  task automatic test_bit_order();
    int t, ofs;
    logic [NREQ-1:0] g, d;
    logic [7:0] rx, exp_log;
    logic exp_first;
`ifdef SPI_LSB_FIRST_EN
    exp_first = 1'b1; exp_log = 8'h80;
`else
    exp_first = 1'b0; exp_log = 8'h01;
`endif
    slave_byte = 8'h80; slave_cnt = 3'd0; mosi_log = 8'h00; log_en = 1'b1;
    set_req(1, 8'h01, 2'd2);
    req = 4'b0010;
    wait_grant(t, g);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL order_gnt: got %b want 0010", g); end
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    checks++; if (mosi !== exp_first) begin errors++; $display("FAIL order_first_bit: got %b want %b", mosi, exp_first); end
    checks++; if (ss_n !== 3'b011) begin errors++; $display("FAIL order_ss_n: got %b want 011", ss_n); end
    wait_done(t, ofs, d, rx);
    log_en = 1'b0;
    checks++; if (d !== 4'b0010) begin errors++; $display("FAIL order_done: got %b want 0010", d); end
    checks++; if (rx !== 8'h80) begin errors++; $display("FAIL order_rx: got %h want 80", rx); end
    checks++; if (mosi_log !== exp_log) begin errors++; $display("FAIL order_mosi: got %h want %h", mosi_log, exp_log); end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_pointer();
    test_out_of_range();
    test_reset_mid();
    test_bit_order();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
